// File: rtl/modexp_host_seq_if.sv
// Bundle of signals between the ModExp host sequencer and its neighbours:
// the host (go/done), the rtMod and modInv precompute blocks, and ModExp.
// slave  : the sequencer's view (it answers the host's go).
// master : the environment's view (host, precompute engines, ModExp).
interface modexp_host_seq_if #(
    parameter int WIDTH = 4096,
    parameter int DW    = 64
);
    // Host side
    logic             go;
    logic [WIDTH-1:0] message;
    logic [WIDTH-1:0] exponent;
    logic [WIDTH-1:0] modulus;
    logic             busy;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] cypher;

    // rtMod (R / T precompute)
    logic             pre_go;
    logic             pre_mode;
    logic [WIDTH-1:0] pre_n;
    logic [WIDTH-1:0] pre_result;
    logic             pre_done;

    // modInv (nprime0 precompute)
    logic             inv_go;
    logic [63:0]      inv_result;
    logic             inv_valid;

    // ModExp
    logic [DW-1:0]    m_buf;
    logic [DW-1:0]    e_buf;
    logic [DW-1:0]    n_buf;
    logic [DW-1:0]    r_buf;
    logic [DW-1:0]    t_buf;
    logic [63:0]      nprime0;
    logic             startInput;
    logic             startCompute;
    logic             getResult;
    logic [4:0]       exp_state;
    logic [DW-1:0]    res_out;

    modport slave (
        input  go, message, exponent, modulus,
        input  pre_result, pre_done, inv_result, inv_valid, exp_state, res_out,
        output busy, done, error, cypher,
        output pre_go, pre_mode, pre_n, inv_go,
        output m_buf, e_buf, n_buf, r_buf, t_buf, nprime0,
        output startInput, startCompute, getResult
    );

    modport master (
        output go, message, exponent, modulus,
        output pre_result, pre_done, inv_result, inv_valid, exp_state, res_out,
        input  busy, done, error, cypher,
        input  pre_go, pre_mode, pre_n, inv_go,
        input  m_buf, e_buf, n_buf, r_buf, t_buf, nprime0,
        input  startInput, startCompute, getResult
    );
endinterface

// File: rtl/modexp_host_seq.sv
// ModExp host sequencer: latches the operands on go, runs the R -> T ->
// nprime0 precompute chain, streams every operand word into ModExp, waits
// for its COMPLETE state and reassembles the result words into cypher.
// Any wait state that lasts TIMEOUT cycles aborts with a one-cycle error.
module modexp_host_seq #(
    parameter int WIDTH       = 4096,
    parameter int DW          = 64,
    parameter int ST_COMPLETE = 9,
    parameter int TIMEOUT     = 1 << 24
) (
    input  logic                  clk,
    input  logic                  reset,
    modexp_host_seq_if.slave      bus
);
    localparam int NWORDS = WIDTH / DW;
    localparam int KW     = $clog2(NWORDS + 1);
    localparam int TW     = $clog2(TIMEOUT + 1);

    localparam logic [KW-1:0] K_LOAD_LAST = KW'(NWORDS - 1);
    localparam logic [KW-1:0] K_READ_LAST = KW'(NWORDS);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [4:0]    EXP_DONE    = 5'(ST_COMPLETE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC_R,
        S_CALC_T,
        S_CALC_N0,
        S_LOAD,
        S_WAIT_EXP,
        S_READ,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] cypher_q, cypher_d;
    logic [63:0]      nprime0_q, nprime0_d;
    logic             pre_go_q, pre_go_d;
    logic             inv_go_q, inv_go_d;
    logic             error_q, error_d;

    logic waiting;
    logic tmo_expired;

    assign waiting     = (state_q == S_CALC_R) || (state_q == S_CALC_T) ||
                         (state_q == S_CALC_N0) || (state_q == S_WAIT_EXP);
    assign tmo_expired = (tmo_q == TMO_LAST);

    // Next-state, counter and datapath-capture logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        k_d       = k_q;
        m_d       = m_q;
        e_d       = e_q;
        n_d       = n_q;
        r_d       = r_q;
        t_d       = t_q;
        cypher_d  = cypher_q;
        nprime0_d = nprime0_q;
        pre_go_d  = 1'b0;
        inv_go_d  = 1'b0;
        error_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    m_d      = bus.message;
                    e_d      = bus.exponent;
                    n_d      = bus.modulus;
                    cypher_d = '0;
                    pre_go_d = 1'b1;
                    state_d  = S_CALC_R;
                end
            end
            S_CALC_R: begin
                // A pre_done coinciding with our own start pulse is stale.
                if (bus.pre_done && !pre_go_q) begin
                    r_d      = bus.pre_result;
                    pre_go_d = 1'b1;
                    state_d  = S_CALC_T;
                end else if (tmo_expired) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CALC_T: begin
                if (bus.pre_done && !pre_go_q) begin
                    t_d      = bus.pre_result;
                    inv_go_d = 1'b1;
                    state_d  = S_CALC_N0;
                end else if (tmo_expired) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CALC_N0: begin
                if (bus.inv_valid && !inv_go_q) begin
                    nprime0_d = bus.inv_result;
                    k_d       = '0;
                    state_d   = S_LOAD;
                end else if (tmo_expired) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (k_q == K_LOAD_LAST) begin
                    k_d     = '0;
                    state_d = S_WAIT_EXP;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_WAIT_EXP: begin
                if (bus.exp_state == EXP_DONE) begin
                    k_d     = '0;
                    state_d = S_READ;
                end else if (tmo_expired) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                // Cycle 0 carries no data; cycle k carries result word k-1.
                for (int w = 0; w < NWORDS; w++) begin
                    if (k_q == KW'(w + 1)) begin
                        cypher_d[w*DW +: DW] = bus.res_out;
                    end
                end
                if (k_q == K_READ_LAST) begin
                    k_d     = '0;
                    state_d = S_FINISH;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The wait counter restarts on every state change.
        tmo_d = (waiting && (state_d == state_q)) ? tmo_q + 1'b1 : '0;
    end

    // Control state and every register that is visible on an output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            tmo_q     <= '0;
            n_q       <= '0;
            cypher_q  <= '0;
            nprime0_q <= '0;
            pre_go_q  <= 1'b0;
            inv_go_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
            state_q   <= state_d;
            k_q       <= k_d;
            tmo_q     <= tmo_d;
            n_q       <= n_d;
            cypher_q  <= cypher_d;
            nprime0_q <= nprime0_d;
            pre_go_q  <= pre_go_d;
            inv_go_q  <= inv_go_d;
            error_q   <= error_d;
        end
    end

    // Internal operand storage, only ever observed through the LOAD-gated buffers.
    always_ff @(posedge clk) begin
        // NOTE: wide datapath registers are deliberately left out of reset; they are rewritten before use.
        m_q <= m_d;
        e_q <= e_d;
        r_q <= r_d;
        t_q <= t_d;
    end

    // Word k of every operand during LOAD, zero otherwise.
    always_comb begin
        bus.m_buf = '0;
        bus.e_buf = '0;
        bus.n_buf = '0;
        bus.r_buf = '0;
        bus.t_buf = '0;
        if (state_q == S_LOAD) begin
            for (int w = 0; w < NWORDS; w++) begin
                if (k_q == KW'(w)) begin
                    bus.m_buf = m_q[w*DW +: DW];
                    bus.e_buf = e_q[w*DW +: DW];
                    bus.n_buf = n_q[w*DW +: DW];
                    bus.r_buf = r_q[w*DW +: DW];
                    bus.t_buf = t_q[w*DW +: DW];
                end
            end
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_FINISH);
    assign bus.error        = error_q;
    assign bus.cypher       = cypher_q;
    assign bus.pre_go       = pre_go_q;
    assign bus.pre_mode     = (state_q == S_CALC_T);
    assign bus.pre_n        = n_q;
    assign bus.inv_go       = inv_go_q;
    assign bus.nprime0      = nprime0_q;
    assign bus.startInput   = (state_q == S_LOAD);
    assign bus.startCompute = (state_q == S_WAIT_EXP) || (state_q == S_READ);
    assign bus.getResult    = (state_q == S_WAIT_EXP) || (state_q == S_READ);

endmodule

// File: tb/tb_modexp_host_seq.sv
// Bench for modexp_host_seq: rtMod/modInv stubs and a behavioural ModExp
// (m^e mod n, or a fixed word pattern) around the sequencer, with random
// delays and operands. Expected results are computed from the applied
// operands with plain arithmetic.
module tb_modexp_host_seq;
    localparam int WIDTH       = 4096;
    localparam int DW          = 64;
    localparam int NW          = WIDTH / DW;
    localparam int ST_COMPLETE = 9;
    localparam int TIMEOUT     = 300;
    localparam int BUDGET      = 2000;

    typedef logic [WIDTH-1:0] wide_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    modexp_host_seq_if #(.WIDTH(WIDTH), .DW(DW)) bus ();

    modexp_host_seq #(
        .WIDTH(WIDTH), .DW(DW), .ST_COMPLETE(ST_COMPLETE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input wide_t got, input wide_t exp);
        int w;
        checks++;
        if (got !== exp) begin
            w = 0;
            for (int i = NW - 1; i >= 0; i--)
                if (got[i*DW +: DW] !== exp[i*DW +: DW]) w = i;
            failures++;
            $display("FAIL %s: word %0d got=%h expected=%h", tag, w,
                     got[w*DW +: DW], exp[w*DW +: DW]);
        end
    endtask

    function automatic logic [63:0] modpow(input logic [63:0] b, input logic [63:0] e,
                                           input logic [63:0] n);
        logic [127:0] acc, base, nn;
        nn   = 128'(n);
        acc  = 128'(1) % nn;
        base = 128'(b) % nn;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) acc = (acc * base) % nn;
            base = (base * base) % nn;
        end
        return acc[63:0];
    endfunction

    function automatic wide_t rand_wide();
        wide_t v;
        for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- environment knobs and logs ----------------
    wide_t       r_val, t_val;
    logic [63:0] inv_val;
    bit          pre_glitch, inv_hold, pattern_mode;
    int          max_delay, comp_delay;
    int          pre_modes[$];
    int          inv_cnt;
    int          rt_pend, inv_pend;
    bit          rt_mode;

    wide_t       ld_m, ld_e, ld_n, ld_r, ld_t;
    int          ld_cnt, np_bad, cyc, first_in, last_in, first_comp;
    int          calc_cnt, since;
    bit          comp_prev;
    logic [DW-1:0] res_words[NW];

    // rtMod stub: answers each pre_go after a random delay with R or T.
    initial begin
        bus.pre_done   = 1'b0;
        bus.pre_result = '0;
        rt_pend        = 0;
        forever begin
            @(negedge clk);
            bus.pre_done = 1'b0;
            if (reset) begin
                rt_pend = 0;
            end else begin
                if (rt_pend > 0) begin
                    rt_pend--;
                    if (rt_pend == 0) begin
                        bus.pre_done   = 1'b1;
                        bus.pre_result = rt_mode ? t_val : r_val;
                    end
                end
                if (bus.pre_go) begin
                    rt_mode = bus.pre_mode;
                    pre_modes.push_back(int'(bus.pre_mode));
                    rt_pend = $urandom_range(max_delay, 1);
                    if (pre_glitch && !bus.pre_mode) begin
                        bus.pre_done   = 1'b1;
                        bus.pre_result = ~r_val;
                    end
                end
            end
        end
    end

    // modInv stub: answers each inv_go after a random delay unless withheld.
    initial begin
        bus.inv_valid  = 1'b0;
        bus.inv_result = '0;
        inv_pend       = 0;
        forever begin
            @(negedge clk);
            bus.inv_valid = 1'b0;
            if (reset) begin
                inv_pend = 0;
            end else begin
                if (inv_pend > 0) begin
                    inv_pend--;
                    if (inv_pend == 0) begin
                        bus.inv_valid  = 1'b1;
                        bus.inv_result = inv_val;
                    end
                end
                if (bus.inv_go) begin
                    inv_cnt++;
                    if (!inv_hold) inv_pend = $urandom_range(max_delay, 1);
                end
            end
        end
    end

    // Behavioural ModExp: collects streamed words, computes after a delay,
    // then shows COMPLETE and emits result word j-1 in READ cycle j (the
    // READ cycle j happens j+1 cycles after COMPLETE is first shown).
    initial begin
        bus.exp_state = '0;
        bus.res_out   = '0;
        cyc           = 0;
        comp_prev     = 1'b0;
        since         = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                bus.exp_state = '0;
                bus.res_out   = '0;
                comp_prev     = 1'b0;
                since         = -1;
                continue;
            end
            if (bus.startInput) begin
                if (ld_cnt < NW) begin
                    ld_m[ld_cnt*DW +: DW] = bus.m_buf;
                    ld_e[ld_cnt*DW +: DW] = bus.e_buf;
                    ld_n[ld_cnt*DW +: DW] = bus.n_buf;
                    ld_r[ld_cnt*DW +: DW] = bus.r_buf;
                    ld_t[ld_cnt*DW +: DW] = bus.t_buf;
                end
                ld_cnt++;
                if (first_in < 0) first_in = cyc;
                last_in = cyc;
            end
            if ((bus.startInput || bus.startCompute) && bus.nprime0 !== inv_val) np_bad++;
            if (bus.startCompute && !comp_prev) begin
                first_comp = cyc;
                for (int j = 1; j <= NW; j++) begin
                    if (pattern_mode) res_words[j-1] = DW'(100 + j);
                    else res_words[j-1] = (j == 1) ? modpow(ld_m[63:0], ld_e[63:0], ld_n[63:0]) : '0;
                end
                calc_cnt      = (comp_delay > 0) ? comp_delay : $urandom_range(max_delay + 2, 2);
                since         = -1;
                bus.exp_state = 5'd3;
            end else if (bus.startCompute) begin
                if (since < 0) begin
                    calc_cnt--;
                    if (calc_cnt == 0) since = 0;
                end
            end else begin
                bus.exp_state = '0;
                since         = -1;
            end
            if (since >= 0) begin
                bus.exp_state = 5'(ST_COMPLETE);
                bus.res_out   = (since >= 2 && since - 2 < NW) ? res_words[since-2] : 64'hDEAD_BEEF_0BAD_F00D;
                since++;
            end
            comp_prev = bus.startCompute;
        end
    end

    task automatic clear_logs();
        pre_modes.delete();
        inv_cnt    = 0;
        ld_cnt     = 0;
        np_bad     = 0;
        first_in   = -1;
        last_in    = -1;
        first_comp = -1;
        ld_m = '0; ld_e = '0; ld_n = '0; ld_r = '0; ld_t = '0;
    endtask

    // One full operation; checks the handshake, precompute order, streaming and result.
    task automatic run_op(input string tag, input wide_t m, input wide_t e, input wide_t n,
                          input wide_t exp_c, input bit hold_go);
        int    cycles;
        bit    seen;
        wide_t got;
        clear_logs();
        bus.message  = m;
        bus.exponent = e;
        bus.modulus  = n;
        bus.go       = 1'b1;
        @(negedge clk);
        if (!hold_go) bus.go = 1'b0;
        check({tag, ":busy"}, wide_t'(bus.busy), wide_t'(1));
        check({tag, ":pre_n"}, bus.pre_n, n);
        cycles = 0;
        seen   = 1'b0;
        got    = '0;
        while (!seen && cycles < BUDGET) begin
            if (bus.done) begin
                seen   = 1'b1;
                got    = bus.cypher;
                bus.go = 1'b0;
            end else begin
                @(negedge clk);
                cycles++;
            end
        end
        bus.go = 1'b0;
        check({tag, ":done_seen"}, wide_t'(seen), wide_t'(1));
        @(negedge clk);
        check({tag, ":done_pulse_busy"}, wide_t'({bus.done, bus.busy}), wide_t'(0));
        check({tag, ":cypher"}, got, exp_c);
        check({tag, ":cypher_held"}, bus.cypher, exp_c);
        check({tag, ":pre_go_seq"},
              wide_t'(pre_modes.size() * 100 + (pre_modes.size() > 0 ? pre_modes[0] * 10 : 5)
                      + (pre_modes.size() > 1 ? pre_modes[1] : 5)), wide_t'(201));
        check({tag, ":inv_go_cnt"}, wide_t'(inv_cnt), wide_t'(1));
        check({tag, ":load_words"}, wide_t'(ld_cnt), wide_t'(NW));
        check({tag, ":load_contig"}, wide_t'(last_in - first_in + 1), wide_t'(NW));
        check({tag, ":compute_rise"}, wide_t'(first_comp - last_in), wide_t'(1));
        check({tag, ":nprime0_stable"}, wide_t'(np_bad), wide_t'(0));
        check({tag, ":m_stream"}, ld_m, m);
        check({tag, ":e_stream"}, ld_e, e);
        check({tag, ":n_stream"}, ld_n, n);
        check({tag, ":r_stream"}, ld_r, r_val);
        check({tag, ":t_stream"}, ld_t, t_val);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        wide_t m, e, n, exp_c;
        logic [63:0] n64, m64, e64;
        int    cycles, t0, t1;
        bit    found, bad;

        reset        = 1'b1;
        bus.go       = 1'b0;
        bus.message  = '0;
        bus.exponent = '0;
        bus.modulus  = '0;
        pre_glitch   = 1'b0;
        inv_hold     = 1'b0;
        pattern_mode = 1'b0;
        max_delay    = 5;
        comp_delay   = 0;
        r_val        = {NW{64'hA5A5_A5A5_A5A5_A5A5}};
        t_val        = {NW{64'h5A5A_5A5A_5A5A_5A5A}};
        inv_val      = 64'h1234;
        clear_logs();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst:ctrl", wide_t'({bus.busy, bus.done, bus.error, bus.pre_go, bus.pre_mode,
                                   bus.inv_go, bus.startInput, bus.startCompute, bus.getResult}), '0);
        check("rst:cypher", bus.cypher, '0);
        check("rst:pre_n", bus.pre_n, '0);
        check("rst:nprime0", wide_t'(bus.nprime0), '0);
        check("rst:bufs", wide_t'({bus.m_buf, bus.e_buf, bus.n_buf, bus.r_buf, bus.t_buf}), '0);
        reset = 1'b0;
        @(negedge clk);

        // Known-answer run with a stale pre_done on the R start pulse
        pre_glitch = 1'b1;
        run_op("kat", wide_t'(8), wide_t'(13), wide_t'(77), wide_t'(50), 1'b0);
        pre_glitch = 1'b0;

        // Word streaming / readback alignment: message word k = k, pattern result
        pattern_mode = 1'b1;
        for (int k = 0; k < NW; k++) m[k*DW +: DW] = DW'(k);
        exp_c = '0;
        for (int j = 1; j <= NW; j++) exp_c[(j-1)*DW +: DW] = DW'(100 + j);
        r_val   = rand_wide();
        t_val   = rand_wide();
        inv_val = {$urandom, $urandom};
        run_op("stream", m, rand_wide(), rand_wide(), exp_c, 1'b0);
        check("stream:word0", wide_t'(bus.cypher[DW-1:0]), wide_t'(101));
        check("stream:word63", wide_t'(bus.cypher[(NW-1)*DW +: DW]), wide_t'(164));
        pattern_mode = 1'b0;

        // Random modular exponentiations
        for (int it = 0; it < 4; it++) begin
            n64       = 64'({$urandom} | 32'h8000_0001);
            m64       = 64'($urandom) % n64;
            e64       = 64'($urandom_range(65535, 1));
            r_val     = rand_wide();
            t_val     = rand_wide();
            inv_val   = {$urandom, $urandom};
            max_delay = $urandom_range(12, 1);
            run_op($sformatf("rand%0d", it), wide_t'(m64), wide_t'(e64), wide_t'(n64),
                   wide_t'(modpow(m64, e64, n64)), 1'b0);
        end

        // go held high through CALC_T, WAIT_EXP and the rest of the run
        max_delay = 4;
        run_op("go_held", wide_t'(3), wide_t'(5), wide_t'(1000003), wide_t'(243), 1'b1);

        // Reset while waiting on ModExp, then a clean run
        comp_delay = 30;
        clear_logs();
        bus.message  = wide_t'(2);
        bus.exponent = wide_t'(10);
        bus.modulus  = wide_t'(1000);
        bus.go       = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < BUDGET) begin
            if (bus.startCompute) found = 1'b1;
            else begin @(negedge clk); cycles++; end
        end
        check("rst_wait:reached", wide_t'(found), wide_t'(1));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_wait:ctrl", wide_t'({bus.busy, bus.done, bus.error, bus.pre_go, bus.inv_go,
                                        bus.startInput, bus.startCompute, bus.getResult}), '0);
        check("rst_wait:cypher", bus.cypher, '0);
        check("rst_wait:nprime0", wide_t'(bus.nprime0), '0);
        @(negedge clk);
        reset = 1'b0;
        comp_delay = 0;
        @(negedge clk);
        run_op("after_rst", wide_t'(2), wide_t'(10), wide_t'(1000), wide_t'(24), 1'b0);

        // Timeout while modInv withholds its result
        inv_hold = 1'b1;
        clear_logs();
        bus.modulus = wide_t'(77);
        bus.go      = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        found  = 1'b0;
        cycles = 0;
        t0     = 0;
        while (!found && cycles < BUDGET) begin
            if (bus.inv_go) begin found = 1'b1; t0 = cycles; end
            else begin @(negedge clk); cycles++; end
        end
        check("tmo:inv_go", wide_t'(found), wide_t'(1));
        found = 1'b0;
        bad   = 1'b0;
        t1    = 0;
        while (!found && cycles < t0 + TIMEOUT + 50) begin
            if (bus.done) bad = 1'b1;
            if (bus.error) begin found = 1'b1; t1 = cycles; end
            else begin @(negedge clk); cycles++; end
        end
        check("tmo:error_seen", wide_t'(found), wide_t'(1));
        check("tmo:latency_ok", wide_t'((t1 - t0 >= TIMEOUT) && (t1 - t0 <= TIMEOUT + 1)), wide_t'(1));
        check("tmo:no_done", wide_t'(bad), wide_t'(0));
        check("tmo:idle_at_error", wide_t'({bus.busy, bus.startInput, bus.startCompute}), '0);
        @(negedge clk);
        check("tmo:error_pulse", wide_t'({bus.error, bus.done, bus.busy}), '0);
        inv_hold = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/modexp_host_seq.md
Name: modexp_host_seq

Overview:
- Synthesizable sequencer that sits directly upstream and downstream of ModExp.
- Latches full-width message, exponent and modulus operands.
- Runs the precompute chain in order: R via the rtMod instance (mode 0), T via the same instance (mode 1), then nprime0 via modInv.
- Streams all operands into ModExp word by word, waits for the COMPLETE state, and reassembles the result words into a full-width cypher.
- Replaces the bench-side sequencing with RTL so the RSA core can be driven by a single go/done pair.

Parameters:
- WIDTH, 4096, operand/result width in bits.
- DW, 64, ModExp word width; NWORDS = WIDTH/DW; WIDTH must be a multiple of DW.
- ST_COMPLETE, 9, exp_state encoding that signals ModExp result ready.
- TIMEOUT, 2^24, max cycles spent in any wait state before error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- go  in  1  start request, sampled in IDLE only
- message  in  WIDTH  plaintext/ciphertext operand
- exponent  in  WIDTH  exponent operand
- modulus  in  WIDTH  modulus operand
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when cypher is valid
- error  out  1  one-cycle pulse on timeout
- cypher  out  WIDTH  result; held until next go
- pre_go  out  1  one-cycle start pulse to rtMod
- pre_mode  out  1  0 = R, 1 = T
- pre_n  out  WIDTH  latched modulus to rtMod and modInv
- pre_result  in  WIDTH  rtMod result
- pre_done  in  1  rtMod result valid
- inv_go  out  1  one-cycle start pulse to modInv
- inv_result  in  64  modInv result
- inv_valid  in  1  modInv result valid
- m_buf, e_buf, n_buf, r_buf, t_buf  out  DW each  operand word streams
- nprime0  out  64  latched inverse, held stable from LOAD through READ
- startInput  out  1  high during LOAD
- startCompute  out  1  high from end of LOAD until READ ends
- getResult  out  1  high from end of LOAD until READ ends
- exp_state  in  5  ModExp state
- res_out  in  DW  ModExp result word

Behaviour:
- Reset values: all outputs 0, cypher 0, state IDLE. Reset mid-operation aborts immediately; any pending pre_done, inv_valid or exp_state events are ignored until the next go.
- States: IDLE, CALC_R, CALC_T, CALC_N0, LOAD, WAIT_EXP, READ, FINISH.
- IDLE:
  - On go, latch message/exponent/modulus (pre_n = modulus), clear cypher, drive pre_go=1 and pre_mode=0 for one cycle, go to CALC_R.
  - go while busy is ignored.
- CALC_R: on pre_done, latch r = pre_result, pulse pre_go with pre_mode=1, go to CALC_T. pre_done arriving in the same cycle as the entry pulse is ignored.
- CALC_T: on pre_done, latch t, pulse inv_go, go to CALC_N0.
- CALC_N0: on inv_valid, latch nprime0 = inv_result, word counter k=0, go to LOAD.
- LOAD (exactly NWORDS cycles):
  - In cycle k, each *_buf = word k (bits k*DW +: DW) of its operand; startInput=1.
  - After word NWORDS-1: startInput=0, startCompute=1, getResult=1, go to WAIT_EXP.
  - Every word is sent exactly once; no out-of-range word.
- WAIT_EXP: when exp_state == ST_COMPLETE, k=0, go to READ.
- READ (NWORDS+1 cycles, one-cycle latency):
  - The first cycle discards res_out.
  - In cycle j = 1..NWORDS, cypher word j-1 = res_out.
  - Then startCompute=0, getResult=0, go to FINISH.
- FINISH: done=1 for one cycle, go to IDLE. cypher stays stable until the next accepted go.
- Timeout:
  - A cycle counter resets on every state change.
  - If it reaches TIMEOUT in CALC_R, CALC_T, CALC_N0 or WAIT_EXP: error pulse, all handshake outputs 0, return to IDLE, done never asserts.
- Word counter width: clog2(NWORDS+1). Wrap-around is not allowed.

Test Plan:
- Full run with a behavioural ModExp model: message=8, exponent=13, modulus=77 -> done pulses once, cypher=50, busy drops in the same cycle done falls.
- Precompute order: stubs return r=0xA5..A5, t=0x5A..5A, inv=0x1234 -> exactly one pre_go with mode 0, then one with mode 1, then one inv_go; nprime0=0x1234 for the whole of LOAD.
- Word streaming: message word k = k -> m_buf shows 0..63 in 64 consecutive LOAD cycles with startInput=1; no 65th word; startCompute rises the cycle after word 63.
- Readback alignment: model emits res_out = 100+j in READ cycle j -> cypher word 0 = 101, word 63 = 164.
- go asserted during CALC_T and WAIT_EXP is ignored (no extra pre_go); reset asserted in WAIT_EXP -> next cycle IDLE with all outputs 0, and a following go runs cleanly.
- Stub withholds inv_valid -> error pulse after TIMEOUT cycles, done stays 0, then IDLE.
